multi_barrier: RTL and testbench



---
 rtl/multi_barrier.sv | 144 ++++++++++++++
 tb/tb_multi_barrier.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_barrier.sv
// Multi-ID barrier unit for the token ring: tracks per-ID arrival counts and
// generations, and runs blocking or split-phase (arrive now, wait later) barrier ops.
module multi_barrier #(
   parameter int NBAR         = 4,
   parameter int IDW          = 2,
   parameter int CW           = 5,
   parameter int BARRIER_TYPE = 13
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            selBarrier,
   input  logic            arriveOnly,
   input  logic [IDW-1:0]  barrierId,
   input  logic [CW-1:0]   nParticipants,
   input  logic [3:0]      whichCore,
   output logic            done,
   input  logic [31:0]     RingIn,
   input  logic [3:0]      SlotTypeIn,
   input  logic [3:0]      SourceIn,
   output logic [31:0]     barrierRingOut,
   output logic [3:0]      barrierSlotTypeOut,
   output logic [3:0]      barrierSourceOut,
   output logic            barrierDriveRing,
   output logic            barrierWantsToken,
   input  logic            barrierAcquireToken
);

   typedef enum logic [1:0] {
      Idle,
      WaitToken,
      WaitBarrier,
      WaitGen
   } stateT;

   stateT           state;
   logic [CW-1:0]   count [NBAR];
   logic [NBAR-1:0] gen;
   logic [NBAR-1:0] pending;
   logic [NBAR-1:0] myGen;
   logic [IDW-1:0]  latchedId;
   logic            latchedArrive;

   logic [CW-1:0]   nEff;
   logic [CW-1:0]   threshold;
   logic            slotHit;
   logic [IDW-1:0]  slotId;
   logic            complete;
   logic            completeMine;
   logic            genMoved;
   logic            doneComb;
   logic            unusedRing;

   // A participant count of zero behaves as one, so every slot completes.
   assign nEff         = (nParticipants == '0) ? CW'(1) : nParticipants;
   assign threshold    = nEff - CW'(1);
   assign slotHit      = (SlotTypeIn == 4'(BARRIER_TYPE));
   assign slotId       = RingIn[IDW-1:0];
   assign complete     = slotHit && (count[slotId] >= threshold);
   assign completeMine = complete && (slotId == latchedId);
   assign genMoved     = (gen[latchedId] != myGen[latchedId]);
   assign unusedRing   = ^{SourceIn, RingIn[31:IDW]};

   // Every barrier slot on the ring advances its ID's count, whatever this core is doing.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NBAR; i++) count[i] <= '0;
         gen <= '0;
      end else if (slotHit) begin
         if (complete) begin
            count[slotId] <= '0;
            gen[slotId]   <= ~gen[slotId];
         end else begin
            count[slotId] <= count[slotId] + CW'(1);
         end
      end
   end

   // Op sequencer; a grant that coincides with a completion joins the next generation.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state         <= Idle;
         pending       <= '0;
         myGen         <= '0;
         latchedId     <= '0;
         latchedArrive <= 1'b0;
      end else begin
         unique case (state)
            Idle: begin
               if (selBarrier) begin
                  latchedId     <= barrierId;
                  latchedArrive <= arriveOnly;
                  if (pending[barrierId] && arriveOnly) state <= Idle;
                  else if (pending[barrierId])          state <= WaitGen;
                  else                                  state <= WaitToken;
               end
            end
            WaitToken: begin
               if (barrierAcquireToken) begin
                  myGen[latchedId] <= gen[latchedId] ^ completeMine;
                  if (latchedArrive) begin
                     pending[latchedId] <= 1'b1;
                     state              <= Idle;
                  end else begin
                     state <= WaitBarrier;
                  end
               end
            end
            WaitBarrier: begin
               if (completeMine) begin
                  pending[latchedId] <= 1'b0;
                  state              <= Idle;
               end
            end
            WaitGen: begin
               if (completeMine || genMoved) begin
                  pending[latchedId] <= 1'b0;
                  state              <= Idle;
               end
            end
            default: state <= Idle;
         endcase
      end
   end

   // done is decoded from state and the live slot so it lands in the completing cycle.
   always_comb begin
      doneComb = 1'b0;
      unique case (state)
         Idle:        doneComb = selBarrier && arriveOnly && pending[barrierId];
         WaitToken:   doneComb = barrierAcquireToken && latchedArrive;
         WaitBarrier: doneComb = completeMine;
         WaitGen:     doneComb = completeMine || genMoved;
         default:     doneComb = 1'b0;
      endcase
   end

   assign done               = reset && doneComb;
   assign barrierWantsToken  = reset && (state == WaitToken);
   assign barrierDriveRing   = barrierWantsToken && barrierAcquireToken;
   assign barrierRingOut     = {{(32-IDW){1'b0}}, latchedId};
   assign barrierSlotTypeOut = 4'(BARRIER_TYPE);
   assign barrierSourceOut   = whichCore;

endmodule

// File: tb/tb_multi_barrier.sv
// Testbench for multi_barrier: directed scenarios plus random ring traffic,
// checked every cycle against a generation-counting model of the barrier rules.
module tb_multi_barrier;

   localparam int NBAR = 4;
   localparam int IDW  = 2;
   localparam int CW   = 5;
   localparam int BT   = 13;

   logic           clock = 1'b0;
   logic           reset = 1'b0;
   logic           selBarrier = 1'b0;
   logic           arriveOnly = 1'b0;
   logic [IDW-1:0] barrierId = '0;
   logic [CW-1:0]  nParticipants = '0;
   logic [3:0]     whichCore = 4'h5;
   logic           done;
   logic [31:0]    RingIn = '0;
   logic [3:0]     SlotTypeIn = '0;
   logic [3:0]     SourceIn = '0;
   logic [31:0]    barrierRingOut;
   logic [3:0]     barrierSlotTypeOut;
   logic [3:0]     barrierSourceOut;
   logic           barrierDriveRing;
   logic           barrierWantsToken;
   logic           barrierAcquireToken = 1'b0;

   always #5 clock = ~clock;

   multi_barrier #(.NBAR(NBAR), .IDW(IDW), .CW(CW), .BARRIER_TYPE(BT)) dut (
      .clock(clock),
      .reset(reset),
      .selBarrier(selBarrier),
      .arriveOnly(arriveOnly),
      .barrierId(barrierId),
      .nParticipants(nParticipants),
      .whichCore(whichCore),
      .done(done),
      .RingIn(RingIn),
      .SlotTypeIn(SlotTypeIn),
      .SourceIn(SourceIn),
      .barrierRingOut(barrierRingOut),
      .barrierSlotTypeOut(barrierSlotTypeOut),
      .barrierSourceOut(barrierSourceOut),
      .barrierDriveRing(barrierDriveRing),
      .barrierWantsToken(barrierWantsToken),
      .barrierAcquireToken(barrierAcquireToken)
   );

   int nChecks = 0;
   int nFail   = 0;

   // Model: slots seen per ID this generation, generation numbers as plain integers,
   // and the core's one outstanding op (0 none, 1 needs token, 2 blocking, 3 waiting on gen).
   int mCnt   [NBAR];
   int mGen   [NBAR];
   int mMyGen [NBAR];
   bit mPend  [NBAR];
   int opKind = 0;
   int opId   = 0;
   bit opArrive = 1'b0;
   bit expDone  = 1'b0;

   logic doneSeen, driveSeen;
   logic [31:0] ringSeen;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      nChecks++;
      if (actual !== expected) begin
         nFail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Compare process: mid-cycle, check the DUT against the model, then advance the model.
   always @(negedge clock) begin : compare
      int nEff;
      int sid;
      bit slot;
      bit comp;
      bit wants;
      if (!reset) begin
         for (int i = 0; i < NBAR; i++) begin
            mCnt[i] = 0; mGen[i] = 0; mMyGen[i] = 0; mPend[i] = 1'b0;
         end
         opKind = 0; opId = 0; opArrive = 1'b0; expDone = 1'b0;
         checkOutput("resetDone", {31'b0, done}, 32'd0);
         checkOutput("resetDrive", {31'b0, barrierDriveRing}, 32'd0);
         checkOutput("resetWants", {31'b0, barrierWantsToken}, 32'd0);
      end else begin
         nEff  = (nParticipants == '0) ? 1 : int'(nParticipants);
         slot  = (SlotTypeIn == 4'(BT));
         sid   = int'(RingIn[IDW-1:0]);
         comp  = slot && (mCnt[sid] >= nEff - 1);
         wants = (opKind == 1);
         case (opKind)
            0:       expDone = selBarrier && arriveOnly && mPend[barrierId];
            1:       expDone = barrierAcquireToken && opArrive;
            2:       expDone = comp && (sid == opId);
            default: expDone = (comp && (sid == opId)) || (((mGen[opId] - mMyGen[opId]) % 2) != 0);
         endcase
         checkOutput("done", {31'b0, done}, {31'b0, expDone});
         checkOutput("wantsToken", {31'b0, barrierWantsToken}, {31'b0, wants});
         checkOutput("driveRing", {31'b0, barrierDriveRing}, {31'b0, wants && barrierAcquireToken});
         checkOutput("ringOut", barrierRingOut, 32'(opId));
         checkOutput("slotTypeOut", {28'b0, barrierSlotTypeOut}, 32'(BT));
         checkOutput("sourceOut", {28'b0, barrierSourceOut}, {28'b0, whichCore});
         if (slot) begin
            if (comp) begin
               mCnt[sid] = 0;
               mGen[sid]++;
            end else begin
               mCnt[sid]++;
            end
         end
         case (opKind)
            0: if (selBarrier) begin
                  opId = int'(barrierId);
                  opArrive = arriveOnly;
                  if (!mPend[opId]) opKind = 1;
                  else if (!opArrive) opKind = 3;
               end
            1: if (barrierAcquireToken) begin
                  mMyGen[opId] = mGen[opId];
                  if (opArrive) begin
                     mPend[opId] = 1'b1;
                     opKind = 0;
                  end else begin
                     opKind = 2;
                  end
               end
            default: if (expDone) begin
                  mPend[opId] = 1'b0;
                  opKind = 0;
               end
         endcase
      end
   end

   // One cycle of inputs; slotId < 0 puts a non-barrier slot on the ring.
   task automatic applyStimulus(input bit sel, input bit arr, input int id, input int slotId, input bit acq);
      selBarrier = sel;
      arriveOnly = arr;
      barrierId = IDW'(id);
      barrierAcquireToken = acq;
      SourceIn = 4'($urandom_range(0, 15));
      if (slotId >= 0) begin
         SlotTypeIn = 4'(BT);
         RingIn = ($urandom() & ~32'(NBAR - 1)) | 32'(slotId);
      end else begin
         SlotTypeIn = 4'($urandom_range(0, BT - 1));
         RingIn = $urandom();
      end
      @(negedge clock);
      doneSeen = done;
      driveSeen = barrierDriveRing;
      ringSeen = barrierRingOut;
      @(posedge clock);
      #1;
   endtask

   int echoId[$];
   int echoAt[$];

   initial begin
      bit sel;
      bit arr;
      int id;
      int opAge;
      int slotId;
      bit acq;

      repeat (2) applyStimulus(0, 0, 0, -1, 0);
      reset = 1'b1;

      // Blocking barrier, N=4: three foreign slots, then the own slot completes it.
      nParticipants = 5'd4;
      applyStimulus(1, 0, 0, -1, 0);
      applyStimulus(1, 0, 0, -1, 1);
      checkOutput("t1Grant", {31'b0, driveSeen}, 32'd1);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1, 0, 0, 0, 0);
         checkOutput("t1Foreign", {31'b0, doneSeen}, 32'd0);
      end
      applyStimulus(1, 0, 0, 0, 0);
      checkOutput("t1OwnDone", {31'b0, doneSeen}, 32'd1);
      checkOutput("t1Count", 32'(mCnt[0]), 32'd0);
      checkOutput("t1Gen", 32'(mGen[0] % 2), 32'd1);
      applyStimulus(0, 0, 0, -1, 0);

      // Split-phase on ID 2, N=3: arrive, barrier completes, later wait returns at once.
      nParticipants = 5'd3;
      applyStimulus(1, 1, 2, -1, 0);
      applyStimulus(1, 1, 2, -1, 1);
      checkOutput("t2GrantDone", {31'b0, doneSeen}, 32'd1);
      checkOutput("t2Drive", {31'b0, driveSeen}, 32'd1);
      checkOutput("t2RingId", ringSeen, 32'd2);
      checkOutput("t2Pending", {31'b0, mPend[2]}, 32'd1);
      applyStimulus(0, 0, 0, -1, 0);
      for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 2, 0);
      checkOutput("t2Gen", 32'(mGen[2] % 2), 32'd1);
      applyStimulus(1, 0, 2, -1, 0);
      checkOutput("t2IdleNoDone", {31'b0, doneSeen}, 32'd0);
      applyStimulus(1, 0, 2, -1, 0);
      checkOutput("t2WaitGenDone", {31'b0, doneSeen}, 32'd1);
      applyStimulus(0, 0, 0, -1, 0);
      checkOutput("t2PendClear", {31'b0, mPend[2]}, 32'd0);

      // Blocking on ID 1 is untouched by five ID-3 slots.
      nParticipants = 5'd4;
      applyStimulus(1, 0, 1, -1, 0);
      applyStimulus(1, 0, 1, -1, 1);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1, 0, 1, 3, 0);
         checkOutput("t3OtherId", {31'b0, doneSeen}, 32'd0);
      end
      checkOutput("t3Count3", 32'(mCnt[3]), 32'd1);
      checkOutput("t3Gen3", 32'(mGen[3]), 32'd1);
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1, 0, 1, 1, 0);
         if (doneSeen) break;
      end
      checkOutput("t3Finish", {31'b0, doneSeen}, 32'd1);
      applyStimulus(0, 0, 0, -1, 0);

      // nParticipants=0 acts as one: the own slot completes immediately.
      nParticipants = 5'd0;
      applyStimulus(1, 0, 3, -1, 0);
      applyStimulus(1, 0, 3, -1, 1);
      applyStimulus(1, 0, 3, 3, 0);
      checkOutput("t4Done", {31'b0, doneSeen}, 32'd1);
      checkOutput("t4Count", 32'(mCnt[3]), 32'd0);
      applyStimulus(0, 0, 0, -1, 0);

      // Async reset during a granted waitToken cycle.
      nParticipants = 5'd4;
      applyStimulus(1, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0);
      barrierAcquireToken = 1'b1;
      SlotTypeIn = 4'd0;
      #2;
      checkOutput("t5DriveBefore", {31'b0, barrierDriveRing}, 32'd1);
      reset = 1'b0;
      #1;
      checkOutput("t5DriveAsync", {31'b0, barrierDriveRing}, 32'd0);
      checkOutput("t5WantsAsync", {31'b0, barrierWantsToken}, 32'd0);
      applyStimulus(0, 0, 0, -1, 0);
      reset = 1'b1;

      // Lowering nParticipants from 6 to 2 with four arrivals completes on the next slot.
      nParticipants = 5'd6;
      applyStimulus(1, 0, 0, -1, 0);
      applyStimulus(1, 0, 0, -1, 1);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1, 0, 0, 0, 0);
         checkOutput("t6Early", {31'b0, doneSeen}, 32'd0);
      end
      checkOutput("t6Count", 32'(mCnt[0]), 32'd4);
      nParticipants = 5'd2;
      applyStimulus(1, 0, 0, 0, 0);
      checkOutput("t6LoweredDone", {31'b0, doneSeen}, 32'd1);
      checkOutput("t6CountClear", 32'(mCnt[0]), 32'd0);
      applyStimulus(0, 0, 0, -1, 0);

      // Random ops and ring traffic; own slots return four cycles after the grant.
      sel = 1'b0; arr = 1'b0; id = 0; opAge = 0;
      for (int c = 0; c < 3000; c++) begin
         if (sel && expDone) sel = 1'b0;
         if (!sel && opKind == 0 && $urandom_range(0, 3) == 0) begin
            if ($urandom_range(0, 40) == 0) nParticipants = CW'($urandom_range(0, 5));
            sel = 1'b1;
            arr = 1'($urandom_range(0, 1));
            id = $urandom_range(0, NBAR - 1);
            opAge = 0;
         end
         if (sel) opAge++;
         if (opAge > 600) begin
            nChecks++;
            nFail++;
            $display("[TB] FAIL opTimeout: op on ID %0d still open after %0d cycles, required done", id, opAge);
            break;
         end
         acq = (opKind == 1) && ($urandom_range(0, 2) == 0);
         if (acq) begin
            echoId.push_back(opId);
            echoAt.push_back(c + 4);
         end
         slotId = -1;
         if (echoAt.size() > 0 && echoAt[0] == c) begin
            slotId = echoId.pop_front();
            void'(echoAt.pop_front());
         end else if ($urandom_range(0, 1) == 0) begin
            slotId = $urandom_range(0, NBAR - 1);
         end
         applyStimulus(sel, arr, id, slotId, acq);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end

endmodule
